// File: rtl/ldpc_llr_pingpong_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ldpc_llr_pingpong_if                                             |
// | Purpose  : Bundles the soft-bit input stream and the decoder-side control   |
// |            and random-read port of the LLR ping-pong frontend.             |
// | Modports : master - sample source / decoder core (drives the inputs)       |
// |            slave  - the frontend itself                                    |
// | Signals  : code_rate_in, max_iter_in, sync_in, data_in  (stream in)        |
// |            in_ready, overflow                           (stream status)    |
// |            dec_start, dec_code_rate, dec_max_iter       (frame handoff)    |
// |            dec_rd_en, dec_rd_addr, dec_rd_data, dec_done (decoder port)    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface ldpc_llr_pingpong_if #(
   parameter int IN_WID   = 8,
   parameter int D_WID    = 6,
   parameter int ITER_WID = 5,
   parameter int AW       = 14
) ();
   logic                code_rate_in;
   logic [ITER_WID-1:0] max_iter_in;
   logic                sync_in;
   logic [IN_WID-1:0]   data_in;
   logic                in_ready;
   logic                overflow;
   logic                dec_start;
   logic                dec_code_rate;
   logic [ITER_WID-1:0] dec_max_iter;
   logic                dec_rd_en;
   logic [AW-1:0]       dec_rd_addr;
   logic [D_WID-1:0]    dec_rd_data;
   logic                dec_done;

   modport master (
      output code_rate_in, max_iter_in, sync_in, data_in,
      output dec_rd_en, dec_rd_addr, dec_done,
      input  in_ready, overflow, dec_start, dec_code_rate, dec_max_iter, dec_rd_data
   );

   modport slave (
      input  code_rate_in, max_iter_in, sync_in, data_in,
      input  dec_rd_en, dec_rd_addr, dec_done,
      output in_ready, overflow, dec_start, dec_code_rate, dec_max_iter, dec_rd_data
   );
endinterface
`default_nettype wire

// File: rtl/ldpc_llr_pingpong.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ldpc_llr_pingpong                                                |
// | Purpose  : Soft-bit input frontend for the CMMB LDPC decoder. Shifts and    |
// |            symmetrically saturates incoming LLRs, frames them into a       |
// |            two-bank ping-pong buffer (load N+1 while N is decoded),        |
// |            latches code rate / iteration cap per frame and serves          |
// |            1-cycle-latency random reads to the decoder core.               |
// | Ports    : clk   - system clock, rising edge                               |
// |            reset - asynchronous, active-high                               |
// |            bus   - ldpc_llr_pingpong_if.slave (stream in, decoder port)    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ldpc_llr_pingpong #(
   parameter int IN_WID    = 8,
   parameter int D_WID     = 6,
   parameter int SHIFT     = 0,
   parameter int FRAME_LEN = 9216,
   parameter int ITER_WID  = 5,
   parameter int AW        = 14
) (
   input  logic               clk,
   input  logic               reset,
   ldpc_llr_pingpong_if.slave bus
);

   typedef enum logic [1:0] {
      ST_EMPTY    = 2'd0,
      ST_FILLING  = 2'd1,
      ST_FULL     = 2'd2,
      ST_DECODING = 2'd3
   } bank_st_t;

   // Symmetric clamp: the most-negative code is never produced.
   localparam int                       c_sat_mag   = (1 << (D_WID - 1)) - 1;
   localparam logic signed [IN_WID-1:0] c_sat_hi    = IN_WID'(c_sat_mag);
   localparam logic signed [IN_WID-1:0] c_sat_lo    = -c_sat_hi;
   localparam logic [AW-1:0]            c_last_addr = AW'(FRAME_LEN - 1);

   // ---------------------------------------------------------------- state
   bank_st_t            r_st [2];
   logic                r_wb;
   logic                r_rb;
   logic [AW-1:0]       r_wr_cnt;
   logic                r_cr [2];
   logic [ITER_WID-1:0] r_mi [2];
   logic                r_in_ready;
   logic                r_overflow;
   logic                r_dec_start;
   logic                r_dec_cr;
   logic [ITER_WID-1:0] r_dec_mi;
   logic [D_WID-1:0]    r_rd_data;
   logic [D_WID-1:0]    r_mem0 [FRAME_LEN];
   logic [D_WID-1:0]    r_mem1 [FRAME_LEN];

   // ---------------------------------------------------------- sample path
   logic signed [IN_WID-1:0] w_shifted;
   logic [D_WID-1:0]         w_sat;

   assign w_shifted = $signed(bus.data_in) >>> SHIFT;
   assign w_sat     = (w_shifted > c_sat_hi) ? c_sat_hi[D_WID-1:0] :
                      (w_shifted < c_sat_lo) ? c_sat_lo[D_WID-1:0] :
                                               w_shifted[D_WID-1:0];

   // --------------------------------------------------------- event decode
   logic                w_wb_open;
   logic                w_wr_ok;
   logic                w_drop;
   logic                w_wr_last;
   logic                w_first;
   logic                w_release;
   logic                w_rb_n;
   logic                w_wb_n;
   logic                w_rbn_full;
   logic                w_no_dec_n;
   logic                w_start;
   logic                w_start_cr;
   logic [ITER_WID-1:0] w_start_mi;
   bank_st_t            w_st_n [2];
   logic                w_in_ready_n;
   logic                w_rd_in_range;
   logic [D_WID-1:0]    w_rd_word;

   assign w_wb_open = (r_st[r_wb] == ST_EMPTY) || (r_st[r_wb] == ST_FILLING);
   assign w_wr_ok   = bus.sync_in && w_wb_open;
   assign w_drop    = bus.sync_in && !w_wb_open;
   assign w_wr_last = w_wr_ok && (r_wr_cnt == c_last_addr);
   assign w_first   = w_wr_ok && (r_wr_cnt == '0);
   assign w_release = bus.dec_done && (r_st[r_rb] == ST_DECODING);
   assign w_rb_n    = r_rb ^ w_release;
   assign w_wb_n    = r_wb ^ w_wr_last;

   // Start is decided on post-edge state so that a frame completing in the
   // same cycle as a release (or as its own last sample) hands off at once.
   // Only bank rb can ever be DECODING, so checking rb covers both banks.
   assign w_rbn_full = (r_st[w_rb_n] == ST_FULL) || (w_wr_last && (r_wb == w_rb_n));
   assign w_no_dec_n = (r_st[r_rb] != ST_DECODING) || w_release;
   assign w_start    = w_rbn_full && w_no_dec_n;

   // Bypass the per-bank latch when the frame's first sample is also the one
   // that triggers the start (single-sample frames).
   assign w_start_cr = (w_first && (r_wb == w_rb_n)) ? bus.code_rate_in : r_cr[w_rb_n];
   assign w_start_mi = (w_first && (r_wb == w_rb_n)) ? bus.max_iter_in  : r_mi[w_rb_n];

   always_comb begin
      for (int b = 0; b < 2; b++) begin
         w_st_n[b] = r_st[b];
         if (w_wr_ok && (r_wb == 1'(b)))
            w_st_n[b] = w_wr_last ? ST_FULL : ST_FILLING;
         if (w_release && (r_rb == 1'(b)))
            w_st_n[b] = ST_EMPTY;
         if (w_start && (w_rb_n == 1'(b)))
            w_st_n[b] = ST_DECODING;
      end
   end

   // in_ready reflects the bank that will be written after this edge, so the
   // source never sees a stale "ready" once the write bank becomes blocked.
   assign w_in_ready_n = (w_st_n[w_wb_n] == ST_EMPTY) || (w_st_n[w_wb_n] == ST_FILLING);

   assign w_rd_in_range = (32'(bus.dec_rd_addr) < 32'(FRAME_LEN));
   assign w_rd_word     = !w_rd_in_range ? '0 :
                          r_rb ? r_mem1[bus.dec_rd_addr] : r_mem0[bus.dec_rd_addr];

   // ------------------------------------------------------ control + FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_st[0]     <= ST_EMPTY;
         r_st[1]     <= ST_EMPTY;
         r_wb        <= 1'b0;
         r_rb        <= 1'b0;
         r_wr_cnt    <= '0;
         r_cr[0]     <= 1'b0;
         r_cr[1]     <= 1'b0;
         r_mi[0]     <= '0;
         r_mi[1]     <= '0;
         r_in_ready  <= 1'b0;
         r_overflow  <= 1'b0;
         r_dec_start <= 1'b0;
         r_dec_cr    <= 1'b0;
         r_dec_mi    <= '0;
         r_rd_data   <= '0;
      end else begin
         r_st[0]     <= w_st_n[0];
         r_st[1]     <= w_st_n[1];
         r_wb        <= w_wb_n;
         r_rb        <= w_rb_n;
         r_in_ready  <= w_in_ready_n;
         r_dec_start <= w_start;
         if (w_wr_ok)
            r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + 1'b1;
         if (w_first) begin
            r_cr[r_wb] <= bus.code_rate_in;
            r_mi[r_wb] <= bus.max_iter_in;
         end
         if (w_drop)
            r_overflow <= 1'b1;
         if (w_start) begin
            r_dec_cr <= w_start_cr;
            r_dec_mi <= w_start_mi;
         end
         if (bus.dec_rd_en)
            r_rd_data <= w_rd_word;
      end
   end

   // ------------------------------------------------------- bank storage
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         if (r_wb)
            r_mem1[r_wr_cnt] <= w_sat;
         else
            r_mem0[r_wr_cnt] <= w_sat;
      end
   end

   assign bus.in_ready      = r_in_ready;
   assign bus.overflow      = r_overflow;
   assign bus.dec_start     = r_dec_start;
   assign bus.dec_code_rate = r_dec_cr;
   assign bus.dec_max_iter  = r_dec_mi;
   assign bus.dec_rd_data   = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_ldpc_llr_pingpong.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ldpc_llr_pingpong                                             |
// | Purpose  : Scoreboard bench for ldpc_llr_pingpong. The driver pushes the    |
// |            expected dec_start (cycle, code rate, max_iter) and expected    |
// |            read data into queues; a negedge monitor pops and compares.     |
// |            A second instance (SHIFT=2, FRAME_LEN=4) covers shifted clamp.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ldpc_llr_pingpong;

   localparam int FL = 9216;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   ldpc_llr_pingpong_if #(.IN_WID(8), .D_WID(6), .ITER_WID(5), .AW(14)) bus ();
   ldpc_llr_pingpong_if #(.IN_WID(8), .D_WID(6), .ITER_WID(5), .AW(2))  bus2 ();

   ldpc_llr_pingpong #(.IN_WID(8), .D_WID(6), .SHIFT(0), .FRAME_LEN(FL),
                       .ITER_WID(5), .AW(14)) dut (
      .clk(clk), .reset(reset), .bus(bus));

   ldpc_llr_pingpong #(.IN_WID(8), .D_WID(6), .SHIFT(2), .FRAME_LEN(4),
                       .ITER_WID(5), .AW(2)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2));

   typedef struct {
      int         cyc;
      logic       cr;
      logic [4:0] mi;
   } start_t;

   start_t             start_q[$];
   start_t             start_q2[$];
   logic signed [5:0]  rd_q[$];
   logic signed [5:0]  rd_q2[$];
   start_t             se;
   logic signed [5:0]  re;
   logic               rd_vld  = 1'b0;
   logic               rd_vld2 = 1'b0;
   int                 cyc     = 0;
   int                 n_checks = 0;
   int                 n_pass   = 0;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rd_vld  <= bus.dec_rd_en;
      rd_vld2 <= bus2.dec_rd_en;
   end

   always @(posedge clk) begin
      if (cyc > 90000) begin
         $display("FAIL watchdog: cycle %0d exceeded limit 90000", cyc);
         $fatal(1, "bench timeout");
      end
   end

   task automatic chk(string name, int act, int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // ------------------------------------------------------------- monitor
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.dec_start) begin
            if (start_q.size() == 0) chk("unexpected dec_start", int'(bus.dec_start), 0);
            else begin
               se = start_q.pop_front();
               chk("dec_start cycle", cyc, se.cyc);
               chk("dec_code_rate", int'(bus.dec_code_rate), int'(se.cr));
               chk("dec_max_iter", int'(bus.dec_max_iter), int'(se.mi));
            end
         end
         if (rd_vld) begin
            re = rd_q.pop_front();
            chk("dec_rd_data", int'($signed(bus.dec_rd_data)), int'(re));
         end
         if (bus2.dec_start) begin
            if (start_q2.size() == 0) chk("dut2 unexpected dec_start", int'(bus2.dec_start), 0);
            else begin
               se = start_q2.pop_front();
               chk("dut2 dec_start cycle", cyc, se.cyc);
               chk("dut2 dec_code_rate", int'(bus2.dec_code_rate), int'(se.cr));
               chk("dut2 dec_max_iter", int'(bus2.dec_max_iter), int'(se.mi));
            end
         end
         if (rd_vld2) begin
            re = rd_q2.pop_front();
            chk("dut2 dec_rd_data", int'($signed(bus2.dec_rd_data)), int'(re));
         end
      end
   end

   // -------------------------------------------------------------- driver
   // Every drive happens 1 time unit after a rising edge; the value is
   // sampled by the DUT on the following edge.
   task automatic cyc_start();
      @(posedge clk);
      #1;
      bus.sync_in   = 1'b0;
      bus.dec_done  = 1'b0;
      bus.dec_rd_en = 1'b0;
      bus2.sync_in   = 1'b0;
      bus2.dec_done  = 1'b0;
      bus2.dec_rd_en = 1'b0;
   endtask

   task automatic send(logic [7:0] d);
      cyc_start();
      bus.sync_in = 1'b1;
      bus.data_in = d;
   endtask

   task automatic expect_start(logic cr, logic [4:0] mi);
      start_t s;
      s.cyc = cyc + 1; s.cr = cr; s.mi = mi;
      start_q.push_back(s);
   endtask

   task automatic rd(logic [13:0] addr, int exp);
      cyc_start();
      bus.dec_rd_en   = 1'b1;
      bus.dec_rd_addr = addr;
      rd_q.push_back(6'(exp));
   endtask

   // Frame B stimulus: clamp vectors first, then a deterministic sweep.
   function automatic logic [7:0] vb(int j);
      case (j)
         0: return 8'd127;
         1: return 8'h80;   // -128
         2: return 8'hE0;   // -32
         3: return 8'd17;
         4: return 8'hFB;   // -5
         5: return 8'd31;
         6: return 8'hE1;   // -31
         7: return 8'd0;
         default: return 8'((j * 37) % 256);
      endcase
   endfunction

   initial begin
      start_t s2;
      bus.code_rate_in = 1'b0; bus.max_iter_in = '0; bus.sync_in = 1'b0;
      bus.data_in = '0; bus.dec_rd_en = 1'b0; bus.dec_rd_addr = '0; bus.dec_done = 1'b0;
      bus2.code_rate_in = 1'b0; bus2.max_iter_in = '0; bus2.sync_in = 1'b0;
      bus2.data_in = '0; bus2.dec_rd_en = 1'b0; bus2.dec_rd_addr = '0; bus2.dec_done = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset in_ready", int'(bus.in_ready), 0);
      chk("reset overflow", int'(bus.overflow), 0);
      chk("reset dec_rd_data", int'(bus.dec_rd_data), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      cyc_start();
      @(negedge clk);
      chk("in_ready after reset", int'(bus.in_ready), 1);

      // Stray dec_done with nothing decoding is ignored
      cyc_start();
      bus.dec_done = 1'b1;
      cyc_start();
      @(negedge clk);
      chk("in_ready after stray dec_done", int'(bus.in_ready), 1);

      // Shifted saturation on the small instance
      bus2.code_rate_in = 1'b1; bus2.max_iter_in = 5'd5;
      cyc_start(); bus2.sync_in = 1'b1; bus2.data_in = 8'd100;
      cyc_start(); bus2.sync_in = 1'b1; bus2.data_in = 8'h9C;  // -100
      cyc_start(); bus2.sync_in = 1'b1; bus2.data_in = 8'd127;
      cyc_start(); bus2.sync_in = 1'b1; bus2.data_in = 8'h80;  // -128
      s2.cyc = cyc + 1; s2.cr = 1'b1; s2.mi = 5'd5;
      start_q2.push_back(s2);
      for (int a = 0; a < 4; a++) begin
         cyc_start();
         bus2.dec_rd_en = 1'b1;
         bus2.dec_rd_addr = 2'(a);
         case (a)
            0: rd_q2.push_back(6'(25));
            1: rd_q2.push_back(6'(-25));
            2: rd_q2.push_back(6'(31));
            default: rd_q2.push_back(6'(-31));
         endcase
      end

      // Frame A -> bank0, gapless
      bus.code_rate_in = 1'b0; bus.max_iter_in = 5'd20;
      for (int k = 0; k < FL; k++) send(8'(k % 32));
      expect_start(1'b0, 5'd20);
      cyc_start();
      @(negedge clk);
      chk("in_ready after frame A", int'(bus.in_ready), 1);
      rd(14'd9216, 0);
      rd(14'd16383, 0);
      rd(14'd100, 4);
      rd(14'd9215, 31);
      cyc_start();
      cyc_start();
      @(negedge clk);
      chk("rd_data holds", int'($signed(bus.dec_rd_data)), 31);

      // Frame B -> bank1 with sync gaps; dec_done lands on its last sample
      bus.code_rate_in = 1'b1; bus.max_iter_in = 5'd31;
      for (int j = 0; j < FL; j++) begin
         if ((j % 10) < 3) begin
            cyc_start();
            bus.data_in = 8'h7F;
         end
         send(vb(j));
         if (j == FL - 1) bus.dec_done = 1'b1;
      end
      expect_start(1'b1, 5'd31);
      cyc_start();
      @(negedge clk);
      chk("in_ready on done+last", int'(bus.in_ready), 1);
      chk("overflow on done+last", int'(bus.overflow), 0);
      rd(14'd0, 31);
      rd(14'd1, -31);
      rd(14'd2, -31);
      rd(14'd3, 17);
      rd(14'd4, -5);
      rd(14'd6, -31);
      rd(14'd14, 6);
      rd(14'd21, 9);
      rd(14'd9215, -31);

      // Frame C -> bank0 while bank1 decodes; then blocked and dropping
      bus.code_rate_in = 1'b0; bus.max_iter_in = 5'd17;
      for (int k = 0; k < FL; k++) send(8'((k % 32) - 16));
      cyc_start();
      @(negedge clk);
      chk("in_ready blocked", int'(bus.in_ready), 0);
      chk("overflow before drop", int'(bus.overflow), 0);
      repeat (3) send(8'd5);
      cyc_start();
      @(negedge clk);
      chk("overflow after drop", int'(bus.overflow), 1);
      chk("in_ready still blocked", int'(bus.in_ready), 0);
      cyc_start();
      bus.dec_done = 1'b1;
      expect_start(1'b0, 5'd17);
      cyc_start();
      @(negedge clk);
      chk("in_ready after release", int'(bus.in_ready), 1);
      rd(14'd7, -9);
      rd(14'd9215, 15);
      rd(14'd0, -16);

      // Partial frame D aborted by asynchronous reset
      bus.code_rate_in = 1'b1; bus.max_iter_in = 5'd9;
      repeat (5000) send(8'd3);
      cyc_start();
      #2;
      reset = 1'b1;
      #1;
      chk("async reset in_ready", int'(bus.in_ready), 0);
      chk("async reset overflow", int'(bus.overflow), 0);
      chk("async reset dec_start", int'(bus.dec_start), 0);
      chk("async reset dec_max_iter", int'(bus.dec_max_iter), 0);
      chk("async reset dec_rd_data", int'(bus.dec_rd_data), 0);
      cyc_start();
      cyc_start();
      reset = 1'b0;
      #1;
      chk("in_ready before first edge", int'(bus.in_ready), 0);
      cyc_start();
      @(negedge clk);
      chk("in_ready after mid-frame reset", int'(bus.in_ready), 1);

      // Frame E -> bank0 from address 0
      bus.code_rate_in = 1'b1; bus.max_iter_in = 5'd13;
      for (int k = 0; k < FL; k++) send(8'(-((k % 31) + 1)));
      expect_start(1'b1, 5'd13);
      cyc_start();
      @(negedge clk);
      chk("overflow after frame E", int'(bus.overflow), 0);
      rd(14'd0, -1);
      rd(14'd1, -2);
      rd(14'd9215, -9);

      repeat (4) cyc_start();
      @(negedge clk);
      chk("dec_start queue drained", start_q.size(), 0);
      chk("read queue drained", rd_q.size(), 0);
      chk("dut2 dec_start queue drained", start_q2.size(), 0);
      chk("dut2 read queue drained", rd_q2.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
